// File: rtl/dac_spi_receiver.sv
// SPI slave receiver for 16-bit DAC words, crossing from the SPI pins into the okClk domain.
// Optional macro DAC_SPI_RX_FIFO_EN selects a 4-entry FWFT FIFO instead of a single holding register.
module dac_spi_receiver (
  input  logic        okClk,
  input  logic        reset,
  input  logic        spi_sclk,
  input  logic        spi_sdio,
  input  logic        spi_cs_n,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        frame_err,
  output logic        overflow,
  output logic        busy
);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

  // [0],[1] = synchronizer, [2] = history for edge detection
  logic [2:0] r_sclk_s, r_sdio_s, r_cs_s;

  // NOTE: every clocked block uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge okClk) begin
    if (reset) begin
      r_sclk_s <= 3'b111;
      r_cs_s   <= 3'b111;
      r_sdio_s <= 3'b000;
    end else begin
      r_sclk_s <= {r_sclk_s[1:0], spi_sclk};
      r_cs_s   <= {r_cs_s[1:0], spi_cs_n};
      r_sdio_s <= {r_sdio_s[1:0], spi_sdio};
    end
  end

  logic w_sclk_rise, w_cs_rise, w_cs_fall, w_sdio;
  assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_s[2];
  assign w_cs_rise   = r_cs_s[1] & ~r_cs_s[2];
  assign w_cs_fall   = ~r_cs_s[1] & r_cs_s[2];
  // Data has been stable since the preceding sclk fall, at least three cycles earlier.
  assign w_sdio      = r_sdio_s[2];

  state_t      r_state;
  logic [15:0] r_shift;
  logic [4:0]  r_bit_cnt;
  logic [1:0]  r_settle;
  logic        r_frame_err, r_busy, r_overflow;

  logic [15:0] w_shift_next;
  logic [4:0]  w_cnt_next;
  logic        w_commit;

  // A sclk rise coinciding with the cs_n rise is counted before the length is judged.
  // NOTE: defaults first in always_comb so no path leaves a signal unassigned (no latch).
  always_comb begin
    w_shift_next = r_shift;
    w_cnt_next   = r_bit_cnt;
    if (w_sclk_rise) begin
      w_shift_next = {r_shift[14:0], w_sdio};
      if (r_bit_cnt != 5'd17) w_cnt_next = r_bit_cnt + 5'd1;
    end
  end

  assign w_commit = (r_state == SHIFT) && w_cs_rise && (w_cnt_next == 5'd16);

  // r_settle lets the synchronizers flush their reset value before cs_n is trusted.
  always_ff @(posedge okClk) begin
    if (reset) begin
      r_state     <= WAIT_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_settle    <= '0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        WAIT_IDLE: begin
          if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
          else if (r_cs_s[1])   r_state  <= IDLE;
        end
        IDLE: begin
          if (w_cs_fall) begin
            r_state   <= SHIFT;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_busy    <= 1'b1;
          end
        end
        SHIFT: begin
          r_shift   <= w_shift_next;
          r_bit_cnt <= w_cnt_next;
          if (w_cs_rise) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_frame_err <= (w_cnt_next != 5'd16);
          end
        end
        default: begin
          r_state  <= WAIT_IDLE;
          r_settle <= '0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign frame_err = r_frame_err;
  assign busy      = r_busy;
  assign overflow  = r_overflow;

`ifdef DAC_SPI_RX_FIFO_EN
  logic [15:0] r_mem [4];
  logic [1:0]  r_wr_ptr, r_rd_ptr;
  logic [2:0]  r_count;
  logic        w_pop, w_full, w_push;

  assign w_pop  = (r_count != 3'd0) && rx_ready;
  assign w_full = (r_count == 3'd4);
  assign w_push = w_commit && (!w_full || w_pop);

  always_ff @(posedge okClk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_commit && w_full && !w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the occupancy count alone decides what is valid.
  always_ff @(posedge okClk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_shift_next;
  end

  assign rx_valid = (r_count != 3'd0);
  assign rx_data  = rx_valid ? r_mem[r_rd_ptr] : 16'h0000;
`else
  logic [15:0] r_hold;
  logic        r_valid;
  logic        w_pop, w_push;

  assign w_pop  = r_valid && rx_ready;
  assign w_push = w_commit && (!r_valid || w_pop);

  always_ff @(posedge okClk) begin
    if (reset) begin
      r_hold     <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_commit && r_valid && !w_pop;
      if (w_push) begin
        r_hold  <= w_shift_next;
        r_valid <= 1'b1;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_valid = r_valid;
  assign rx_data  = r_hold;
`endif

endmodule

// File: tb/tb_dac_spi_receiver.sv
// Directed-plus-random bench for dac_spi_receiver, compared against a frame-level reference model.
module tb_dac_spi_receiver;

`ifdef DAC_SPI_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        okClk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_sclk = 1'b1;
  logic        spi_sdio = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        rx_ready = 1'b1;
  logic [15:0] rx_data;
  logic        rx_valid, frame_err, overflow, busy;

  dac_spi_receiver dut (
    .okClk(okClk), .reset(reset), .spi_sclk(spi_sclk), .spi_sdio(spi_sdio),
    .spi_cs_n(spi_cs_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overflow(overflow), .busy(busy)
  );

  always #5 okClk = ~okClk;

  int total = 0;
  int bad   = 0;

  // Observed events, sampled on the falling edge where everything is settled.
  int          fe_cnt = 0, ov_cnt = 0, rv_cycles = 0, stall_viol = 0;
  logic [15:0] popped [$];
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data  = '0;

  always @(negedge okClk) begin
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (overflow)  ov_cnt <= ov_cnt + 1;
      if (rx_valid)  rv_cycles <= rv_cycles + 1;
      if (rx_valid && rx_ready) popped.push_back(rx_data);
      if (prev_stall && (!rx_valid || rx_data !== prev_data)) stall_viol <= stall_viol + 1;
      prev_stall <= rx_valid && !rx_ready;
      prev_data  <= rx_data;
    end
  end

  // Reference model: whole frames in, words out.
  logic [15:0] exp_out [$];
  logic [15:0] model_buf [$];
  int          exp_fe = 0, exp_ov = 0;

  task automatic model_frame(input logic [15:0] word, input int nbits);
    if (nbits != 16)            exp_fe++;
    else if (rx_ready)          exp_out.push_back(word);
    else if (model_buf.size() < DEPTH) model_buf.push_back(word);
    else                        exp_ov++;
  endtask

  task automatic model_drain();
    while (model_buf.size() > 0) exp_out.push_back(model_buf.pop_front());
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge okClk);
      #2;
    end
  endtask

  task automatic drive_bit(input logic b, input int half, input bit last_tight);
    spi_sclk = 1'b0;
    spi_sdio = b;
    tick(half);
    spi_sclk = 1'b1;
    if (!last_tight) tick(half);
  endtask

  // tight: cs_n rises in the same instant as the final sclk rise.
  task automatic send_frame(input logic [15:0] word, input int nbits, input int half, input bit tight);
    logic [15:0] w;
    w = word;
    spi_cs_n = 1'b0;
    tick(half);
    for (int i = 0; i < nbits; i++)
      drive_bit((i < 16) ? w[15 - i] : 1'($urandom_range(0, 1)), half, tight && (i == nbits - 1));
    spi_cs_n = 1'b1;
    tick(10);
  endtask

  initial begin
    int          rv0, fe0, pop0, nb, hf;
    logic [15:0] wd;

    tick(4);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick(12);

    // Nominal frame with slow sclk: exactly one cycle of rx_valid.
    rv0 = rv_cycles;
    send_frame(16'hA5C3, 16, 126, 1'b0);
    model_frame(16'hA5C3, 16);
    check("a5c3_valid_cycles", 32'(rv_cycles - rv0), 32'd1);
    check("a5c3_word", 32'(popped[popped.size() - 1]), 32'hA5C3);
    check("a5c3_no_err", 32'(fe_cnt), 32'(exp_fe));

    // Short and long frames.
    rv0 = rv_cycles;
    send_frame(16'hFFFF, 12, 4, 1'b0);
    model_frame(16'hFFFF, 12);
    check("short_frame_err", 32'(fe_cnt), 32'(exp_fe));
    check("short_no_valid", 32'(rv_cycles - rv0), 32'd0);
    rv0 = rv_cycles;
    send_frame(16'h1357, 18, 3, 1'b0);
    model_frame(16'h1357, 18);
    check("long_frame_err", 32'(fe_cnt), 32'(exp_fe));
    check("long_no_valid", 32'(rv_cycles - rv0), 32'd0);

    // sclk activity while deselected is ignored.
    fe0 = fe_cnt; pop0 = popped.size();
    for (int i = 0; i < 5; i++) begin
      spi_sclk = 1'b0; tick(4); spi_sclk = 1'b1; tick(4);
    end
    check("idle_sclk_no_err", 32'(fe_cnt - fe0), 32'd0);
    check("idle_sclk_no_word", 32'(popped.size() - pop0), 32'd0);

    // Final sclk rise and cs_n rise in the same cycle.
    send_frame(16'h5A3C, 16, 3, 1'b1);
    model_frame(16'h5A3C, 16);
    send_frame(16'h0F0F, 15, 3, 1'b1);
    model_frame(16'h0F0F, 15);
    check("tight_frame_err", 32'(fe_cnt), 32'(exp_fe));

    // Random frames.
    for (int k = 0; k < 10; k++) begin
      wd = 16'($urandom);
      nb = ($urandom_range(0, 2) != 0) ? 16 : int'($urandom_range(8, 20));
      hf = int'($urandom_range(3, 7));
      send_frame(wd, nb, hf, 1'($urandom_range(0, 1)));
      model_frame(wd, nb);
    end
    check("random_frame_errs", 32'(fe_cnt), 32'(exp_fe));

    // Back-pressure: five words into a stalled buffer.
    rx_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      send_frame(16'(k), 16, 3, 1'b0);
      model_frame(16'(k), 16);
    end
    check("stall_valid", 32'(rx_valid), 32'd1);
    check("stall_head", 32'(rx_data), 32'h0001);
    check("stall_overflows", 32'(ov_cnt), 32'(exp_ov));
    rx_ready = 1'b1;
    model_drain();
    tick(20);
    check("drained_valid", 32'(rx_valid), 32'd0);

    // Reset in the middle of a frame aborts it silently.
    spi_cs_n = 1'b0;
    tick(4);
    for (int i = 0; i < 8; i++) drive_bit(1'($urandom_range(0, 1)), 4, 1'b0);
    check("midframe_busy", 32'(busy), 32'd1);
    fe0 = fe_cnt; pop0 = popped.size();
    reset = 1'b1;
    tick(2);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_rx_data", 32'(rx_data), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) drive_bit(1'($urandom_range(0, 1)), 4, 1'b0);
    spi_cs_n = 1'b1;
    tick(12);
    check("abort_no_err", 32'(fe_cnt - fe0), 32'd0);
    check("abort_no_word", 32'(popped.size() - pop0), 32'd0);
    send_frame(16'h1234, 16, 5, 1'b0);
    model_frame(16'h1234, 16);
    check("after_reset_word", 32'(popped[popped.size() - 1]), 32'h1234);

    // Whole-run comparison against the model.
    check("word_count", 32'(popped.size()), 32'(exp_out.size()));
    for (int i = 0; i < exp_out.size() && i < popped.size(); i++)
      check($sformatf("word_%0d", i), 32'(popped[i]), 32'(exp_out[i]));
    check("total_frame_errs", 32'(fe_cnt), 32'(exp_fe));
    check("total_overflows", 32'(ov_cnt), 32'(exp_ov));
    check("stall_stability", 32'(stall_viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dac_spi_receiver.md
DAC_SPI_RECEIVER -- requirements
Module: dac_spi_receiver

Interface
REQ-001 SHALL have port: okClk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: spi_sclk  input  1  SPI clock, asynchronous to okClk, idles high.
REQ-004 SHALL have port: spi_sdio  input  1  SPI serial data, MSB first, changes on sclk fall.
REQ-005 SHALL have port: spi_cs_n  input  1  SPI chip select, active-low, asynchronous.
REQ-006 SHALL have port: rx_data  output  16  received word at head of output buffer.
REQ-007 SHALL have port: rx_valid  output  1  rx_data holds a valid word.
REQ-008 SHALL have port: rx_ready  input  1  consumer accepts word when rx_valid && rx_ready.
REQ-009 SHALL have port: frame_err  output  1  one-cycle pulse: frame ended with bit count != 16.
REQ-010 SHALL have port: overflow  output  1  one-cycle pulse: complete word dropped, buffer full.
REQ-011 SHALL have port: busy  output  1  high while state is SHIFT.

Function
REQ-012 SHALL pass spi_sclk, spi_sdio, spi_cs_n through 2-FF synchronizers plus one history stage; edges detected from last two stages.
REQ-013 SHALL require sclk high and low phases each >= 3 okClk cycles; faster input is out of scope.
REQ-014 SHALL implement states WAIT_IDLE, IDLE, SHIFT.
REQ-015 WAIT_IDLE -> IDLE when synchronized cs_n is high; no sampling in WAIT_IDLE.
REQ-016 IDLE -> SHIFT on detected cs_n falling edge; shift register and 5-bit bit_cnt cleared to 0.
REQ-017 In SHIFT, each detected sclk rising edge SHALL shift synchronized sdio into LSB and increment bit_cnt, saturating at 17.
REQ-018 SHALL ignore sclk edges outside SHIFT.
REQ-019 SHIFT -> IDLE on detected cs_n rising edge; bit_cnt == 16 -> commit word; otherwise discard and pulse frame_err the next cycle.
REQ-020 sclk rise and cs_n rise detected in same cycle: SHALL count the sclk edge first, then evaluate bit_cnt.
REQ-021 Commit: word enters buffer on the okClk edge after cs_n rise detection; rx_valid high from that edge if buffer was empty.
REQ-022 Commit with buffer full and no pop that cycle: word dropped, overflow pulse, buffer unchanged.
REQ-023 Commit and pop in the same cycle with buffer full: both SHALL occur, no overflow.
REQ-024 rx_data/rx_valid SHALL stay stable while rx_valid && !rx_ready.
REQ-025 Bit order: first sampled bit becomes rx_data[15], 16th becomes rx_data[0].

Reset
REQ-026 On reset: state WAIT_IDLE, buffer empty, rx_valid 0, rx_data 16'h0000, frame_err 0, overflow 0, busy 0, bit_cnt 0.
REQ-027 Synchronizer stages SHALL reset to 1 for sclk and cs_n, 0 for sdio.
REQ-028 Reset mid-frame SHALL abort silently (no frame_err); remainder of that frame ignored via WAIT_IDLE.

Configuration
REQ-029 Macro DAC_SPI_RX_FIFO_EN defined: output buffer SHALL be 4-entry FIFO, first-word-fall-through, 2-bit pointers wrapping 3 -> 0, 3-bit occupancy count.
REQ-030 Macro DAC_SPI_RX_FIFO_EN undefined: output buffer SHALL be a single holding register; "full" means rx_valid high.

Verification
REQ-031 Frame 16'hA5C3, 126-cycle half periods, rx_ready=1 -> rx_valid one cycle, rx_data=16'hA5C3, no frame_err/overflow.
REQ-032 Frame of 12 sclk rises then cs_n high -> frame_err single pulse, rx_valid stays 0.
REQ-033 Frame of 18 sclk rises -> frame_err pulse, no word committed.
REQ-034 rx_ready=0, send 16'h0001..16'h0005 -> FIFO_EN: 4 words held, overflow on 5th; no FIFO_EN: 16'h0001 held, overflow on 2nd..5th; draining returns words in order.
REQ-035 Assert reset after 8 sclk rises, release, finish frame -> no frame_err, no rx_valid; next full frame 16'h1234 received correctly.
